// File: rtl/inst_buffer.sv
// Instruction buffer: circular FIFO between fetch and decode. Optional same-cycle
// fetch-to-decode forwarding when empty is compiled in with IB_BYPASS_EN.
package inst_buffer_pkg;
    localparam logic [31:0] IB_NOP = 32'h00000013;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
    } IB_DP_PACKET;
endpackage

module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     if_valid,
    input  logic [31:0]              if_inst,
    input  logic [31:0]              if_pc,
    input  logic [31:0]              if_npc,
    output logic                     if_ready,
    input  logic                     dp_ready,
    output IB_DP_PACKET              dp_packet,
    input  logic                     squash,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   mem_inst [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_npc  [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;

    logic fifo_valid;
    logic bypass;
    logic push;
    logic store;
    logic pop_fifo;

    // A full buffer refuses the push even when the head pops this cycle.
    assign if_ready   = (count < CW'(DEPTH)) && !squash;
    assign push       = if_valid && if_ready;
    assign fifo_valid = (count != '0) && !squash;
    assign pop_fifo   = fifo_valid && dp_ready;

`ifdef IB_BYPASS_EN
    assign bypass = (count == '0) && if_valid && !squash;
`else
    assign bypass = 1'b0;
`endif

    // A forwarded instruction the decoder takes immediately never occupies an entry.
    assign store = push && !(bypass && dp_ready);

    always_comb begin
        dp_packet.valid = 1'b0;
        dp_packet.inst  = IB_NOP;
        dp_packet.pc    = '0;
        dp_packet.npc   = '0;
`ifdef IB_BYPASS_EN
        if (bypass) begin
            dp_packet.valid = 1'b1;
            dp_packet.inst  = if_inst;
            dp_packet.pc    = if_pc;
            dp_packet.npc   = if_npc;
        end else
`endif
        if (fifo_valid) begin
            dp_packet.valid = 1'b1;
            dp_packet.inst  = mem_inst[head];
            dp_packet.pc    = mem_pc[head];
            dp_packet.npc   = mem_npc[head];
        end
    end

    always_ff @(posedge clock) begin
        if (store) begin
            mem_inst[tail] <= if_inst;
            mem_pc[tail]   <= if_pc;
            mem_npc[tail]  <= if_npc;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (squash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (store)
                tail <= tail + AW'(1);
            if (pop_fifo)
                head <= head + AW'(1);
            if (store && !pop_fifo)
                count <= count + CW'(1);
            else if (!store && pop_fifo)
                count <= count - CW'(1);
        end
    end
endmodule

// File: tb/tb_inst_buffer.sv
// Randomized and directed bench for inst_buffer against a queue-based reference model.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
    } ent_t;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic                  if_valid;
    logic [31:0]           if_inst;
    logic [31:0]           if_pc;
    logic [31:0]           if_npc;
    logic                  if_ready;
    logic                  dp_ready;
    IB_DP_PACKET           dp_packet;
    logic                  squash;
    logic [$clog2(DEPTH):0] count;

    ent_t        model[$];
    logic [31:0] popped[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .if_valid  (if_valid),
        .if_inst   (if_inst),
        .if_pc     (if_pc),
        .if_npc    (if_npc),
        .if_ready  (if_ready),
        .dp_ready  (dp_ready),
        .dp_packet (dp_packet),
        .squash    (squash),
        .count     (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One clock: drive inputs, compare outputs with the model mid-cycle, advance model at the edge.
    task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic rdy, input logic sq);
        logic e_rdy, e_vld, byp;
        ent_t e;
        ent_t in_ent;
        in_ent.inst = inst;
        in_ent.pc   = pc;
        in_ent.npc  = pc + 32'd4;
        if_valid = v;
        if_inst  = in_ent.inst;
        if_pc    = in_ent.pc;
        if_npc   = in_ent.npc;
        dp_ready = rdy;
        squash   = sq;
        #2;
        e_rdy = (model.size() < DEPTH) && !sq;
        byp   = 1'b0;
`ifdef IB_BYPASS_EN
        byp   = (model.size() == 0) && v && !sq;
`endif
        e_vld = ((model.size() != 0) && !sq) || byp;
        if (byp)
            e = in_ent;
        else if (e_vld)
            e = model[0];
        else begin
            e.inst = IB_NOP;
            e.pc   = '0;
            e.npc  = '0;
        end
        check("if_ready", {31'd0, if_ready}, {31'd0, e_rdy});
        check("dp_valid", {31'd0, dp_packet.valid}, {31'd0, e_vld});
        check("dp_inst", dp_packet.inst, e.inst);
        check("dp_pc", dp_packet.pc, e.pc);
        check("dp_npc", dp_packet.npc, e.npc);
        check("count", 32'(count), 32'(model.size()));
        if (e_vld && rdy && !sq)
            popped.push_back(dp_packet.pc);
        if (sq)
            model.delete();
        else begin
            if (e_vld && rdy && !byp)
                void'(model.pop_front());
            if (v && e_rdy && !(byp && rdy))
                model.push_back(in_ent);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        if_valid = 1'b0;
        if_inst  = '0;
        if_pc    = '0;
        if_npc   = '0;
        dp_ready = 1'b0;
        squash   = 1'b0;
        #2;
        check("rst_valid", {31'd0, dp_packet.valid}, 32'd0);
        check("rst_inst", dp_packet.inst, 32'h00000013);
        check("rst_count", 32'(count), 32'd0);
        check("rst_if_ready", {31'd0, if_ready}, 32'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // single push then pop
        cycle(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("single_count", 32'(count), 32'd0);

        // fill plus a rejected ninth offer
        for (int i = 0; i < 9; i++)
            cycle(1'b1, 32'h1000 + 32'(i), 32'h200 + 32'(i) * 4, 1'b0, 1'b0);
        check("full_count", 32'(count), 32'd8);
        check("full_if_ready", {31'd0, if_ready}, 32'd0);
        check("full_head_pc", dp_packet.pc, 32'h200);
        cycle(1'b1, 32'h2000, 32'h300, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // interleaved traffic across pointer wrap
        popped.delete();
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, 32'h3000 + 32'(i), 32'(i) * 4, 1'b0, 1'b0);
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        check("wrap_pops", 32'(popped.size()), 32'd12);
        for (int i = 0; i < popped.size(); i++)
            check("wrap_order", popped[i], 32'(i) * 4);

        // squash with pending push and pop
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 32'h4000 + 32'(i), 32'h500 + 32'(i) * 4, 1'b0, 1'b0);
        check("pre_squash_count", 32'(count), 32'd5);
        cycle(1'b1, 32'h4100, 32'h600, 1'b1, 1'b1);
        check("squash_count", 32'(count), 32'd0);
        check("squash_valid", {31'd0, dp_packet.valid}, 32'd0);

        // asynchronous reset with entries stored
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h5000 + 32'(i), 32'h700 + 32'(i) * 4, 1'b0, 1'b0);
        if_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("arst_valid", {31'd0, dp_packet.valid}, 32'd0);
        check("arst_inst", dp_packet.inst, 32'h00000013);
        check("arst_count", 32'(count), 32'd0);
        model.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

`ifdef IB_BYPASS_EN
        cycle(1'b1, 32'h6000, 32'h40, 1'b1, 1'b0);
        check("bypass_count", 32'(count), 32'd0);
`endif

        for (int i = 0; i < 600; i++)
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
                  1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count; power of two, at least 2.
REQ-002 SHALL have port clock, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port if_valid, input, 1, fetch offers an instruction this cycle.
REQ-005 SHALL have port if_inst, input, 32, fetched instruction word.
REQ-006 SHALL have port if_pc, input, 32, PC of the fetched instruction.
REQ-007 SHALL have port if_npc, input, 32, predicted next PC.
REQ-008 SHALL have port if_ready, output, 1, buffer accepts the fetch offer this cycle.
REQ-009 SHALL have port dp_ready, input, 1, decoder/dispatch consumes the head this cycle.
REQ-010 SHALL have port dp_packet, output, IB_DP_PACKET, head entry (inst, PC, NPC, valid) to the decoder.
REQ-011 SHALL have port squash, input, 1, pipeline flush.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1, occupied entries.

Function
REQ-013 SHALL be a circular FIFO with head and tail pointers that wrap modulo DEPTH, plus an occupancy counter.
REQ-014 SHALL drive if_ready = (count < DEPTH) && !squash; a push occurs when if_valid && if_ready.
REQ-015 SHALL drive dp_packet.valid = (count != 0) && !squash; a pop occurs when dp_packet.valid && dp_ready.
REQ-016 SHALL drive dp_packet inst/PC/NPC combinationally from the head entry when valid.
REQ-017 SHALL drive inst = 32'h00000013 (NOP), PC = 0, NPC = 0 when dp_packet.valid is 0.
REQ-018 SHALL write a pushed entry at tail, tail+1; a pop advances head+1; count +1 push-only, -1 pop-only, unchanged for simultaneous push and pop.
REQ-019 SHALL, when full, deassert if_ready even if a pop occurs the same cycle; the full-to-full push is not accepted.
REQ-020 SHALL, when empty, hold if_ready high, and when REQ-027 is not compiled in, present a pushed entry no earlier than the next cycle (1-cycle minimum latency).
REQ-021 SHALL, on squash, set head = tail = count = 0 at the next edge, dropping any same-cycle push and pop (squash has priority).
REQ-022 SHALL preserve strict FIFO order; no entry is duplicated or skipped across pointer wrap.
REQ-023 SHALL hold dp_packet contents stable while dp_packet.valid && !dp_ready.

Reset
REQ-024 SHALL, on reset_n low, immediately clear head, tail and count to 0, giving dp_packet.valid = 0, dp_packet.inst = NOP and if_ready = 1 (once squash = 0).
REQ-025 SHALL abandon stored entries on reset mid-operation; entry storage need not be reset.
REQ-026 SHALL resume normal operation on the first rising clock edge after reset_n goes high.

Configuration
REQ-027 SHALL, with IB_BYPASS_EN defined, forward if_inst/if_pc/if_npc to dp_packet with valid = 1 in the same cycle when count == 0, if_valid = 1 and squash = 0.
REQ-028 SHALL, under REQ-027, store nothing when dp_ready = 1 (count stays 0), and store the entry normally when dp_ready = 0.
REQ-029 SHALL, without IB_BYPASS_EN, apply REQ-015/REQ-020 only, with no combinational path from the if_* inputs to dp_packet.

Verification
REQ-030 Single push/pop: push inst 32'h00500093 at PC 0x100, with dp_ready = 1 -> next cycle dp_packet.valid = 1 with that inst and PC 0x100; count returns to 0 after the pop (no bypass).
REQ-031 Fill: 8 pushes with dp_ready = 0 -> count = 8 and if_ready = 0; a ninth if_valid is not accepted and the head stays entry 0.
REQ-032 Wrap: 12 pushes and 12 pops interleaved, PCs 0x0 to 0x2C -> pops are received in PC order 0x0 to 0x2C with no gaps.
REQ-033 Squash with count = 5 plus a simultaneous push and pop -> next cycle count = 0 and dp_packet.valid = 0.
REQ-034 Reset asserted with count = 3 -> same-cycle dp_packet.valid = 0, inst = 32'h00000013, count = 0.
REQ-035 IB_BYPASS_EN, empty buffer, if_valid = 1 with PC 0x40 and dp_ready = 1 -> same-cycle dp_packet.valid = 1 with PC 0x40; count stays 0.
